// File: rtl/dfd_tn_pkg.sv
// Shared definitions for the trace hop sink: class encoding, enable-FSM
// states, quiesce length and a saturating counter helper.
package dfd_tn_pkg;

    // Class encoding carried on hop_tr_src
    localparam logic CLS_NTRACE = 1'b0;
    localparam logic CLS_DST    = 1'b1;

    // Cycles the enabled-source output is held at zero while a new mask settles
    localparam int unsigned QUIESCE_LEN = 2;

    typedef enum logic [1:0] {
        EN_IDLE    = 2'd0,
        EN_ACTIVE  = 2'd1,
        EN_QUIESCE = 2'd2
    } en_state_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/dfd_trace_hop_sink_fifo.sv
// Per-class FIFO for the trace hop sink. Zero-cycle read (rdata shows the
// head entry combinationally), push into a full FIFO is accepted when a pop
// happens in the same cycle, and a synchronous clear empties it.
module dfd_trace_hop_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    free_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == {CW{1'b0}});
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign rdata   = mem[rd_ptr];
    // Free entries once this cycle's push/pop/clear has taken effect
    assign free_next = CW'(DEPTH) - cnt_next;

    // Next occupancy from this cycle's push, pop and clear
    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = {CW{1'b0}};
        end else if (do_push && !do_pop) begin
            cnt_next = cnt + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_next = cnt - CW'(1);
        end else begin
            cnt_next = cnt;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            cnt    <= {CW{1'b0}};
        end else begin
            cnt <= cnt_next;
            if (clear) begin
                wr_ptr <= {AW{1'b0}};
                rd_ptr <= {AW{1'b0}};
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dfd_trace_hop_sink.sv
// Trace hop sink: terminates the hop chain, sorts one-hot beats into an
// ntrace and a dst FIFO, raises per-class backpressure, forwards flushes and
// runs the enabled-source handshake FSM.
// Optional feature: define DFD_TRACE_SINK_DROP_CNT_EN to add saturating
// per-class dropped-beat counters.
module dfd_trace_hop_sink
    import dfd_tn_pkg::*;
#(
    parameter int NUM_CORES_IN_PATH   = 4,
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int FIFO_DEPTH          = 16,
    parameter int BP_SKID             = 6,
    localparam int DATA_WIDTH = DATA_WIDTH_IN_BYTES * 8,
    localparam int CORE_W     = (NUM_CORES_IN_PATH > 1) ? $clog2(NUM_CORES_IN_PATH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CORES_IN_PATH-1:0] hop_tr_vld,
    input  logic                         hop_tr_src,
    input  logic [DATA_WIDTH-1:0]        hop_tr_data,
    output logic                         hop_tr_ntrace_bp,
    output logic                         hop_tr_dst_bp,
    output logic                         hop_tr_ntrace_flush,
    output logic                         hop_tr_dst_flush,
    output logic [NUM_CORES_IN_PATH-1:0] hop_tr_enabled_srcs,
    input  logic [NUM_CORES_IN_PATH-1:0] cfg_enabled_srcs,
    input  logic                         ntrace_flush_req,
    input  logic                         dst_flush_req,
    output logic                         ntrace_out_vld,
    input  logic                         ntrace_out_rdy,
    output logic [DATA_WIDTH-1:0]        ntrace_out_data,
    output logic [CORE_W-1:0]            ntrace_out_core,
    output logic                         dst_out_vld,
    input  logic                         dst_out_rdy,
    output logic [DATA_WIDTH-1:0]        dst_out_data,
    output logic [CORE_W-1:0]            dst_out_core,
    output logic                         err_onehot,
    output logic                         ntrace_ovf,
    output logic                         dst_ovf
`ifdef DFD_TRACE_SINK_DROP_CNT_EN
    ,
    output logic [15:0]                  ntrace_drop_cnt,
    output logic [15:0]                  dst_drop_cnt
`endif
);

    localparam int ONES_W = $clog2(NUM_CORES_IN_PATH + 1);
    localparam int ENT_W  = CORE_W + DATA_WIDTH;
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    logic [ONES_W-1:0]            vld_ones;
    logic [CORE_W-1:0]            core_idx;
    logic                         is_beat;
    logic                         is_multi;
    logic                         push_n, push_d, pop_n, pop_d;
    logic                         full_n, full_d, empty_n, empty_d;
    logic                         drop_n, drop_d;
    logic [FCW-1:0]               free_n, free_d;
    logic [ENT_W-1:0]             rdata_n, rdata_d;
    en_state_t                    state;
    logic [NUM_CORES_IN_PATH-1:0] mask;
    logic [1:0]                   qcnt;
    logic                         fifo_clear;

    // Count set valid bits and encode the (last) set bit as the core index
    always_comb begin
        vld_ones = {ONES_W{1'b0}};
        core_idx = {CORE_W{1'b0}};
        for (int i = 0; i < NUM_CORES_IN_PATH; i++) begin
            if (hop_tr_vld[i]) begin
                vld_ones = vld_ones + ONES_W'(1);
                core_idx = CORE_W'(i);
            end else begin
                vld_ones = vld_ones;
            end
        end
    end

    assign is_beat  = (vld_ones == ONES_W'(1));
    assign is_multi = (vld_ones > ONES_W'(1));
    assign push_n   = is_beat & (hop_tr_src == CLS_NTRACE);
    assign push_d   = is_beat & (hop_tr_src == CLS_DST);
    assign pop_n    = ntrace_out_vld & ntrace_out_rdy;
    assign pop_d    = dst_out_vld & dst_out_rdy;
    // A beat is lost only when its FIFO is full and not draining this cycle
    assign drop_n   = push_n & full_n & ~pop_n & ~fifo_clear;
    assign drop_d   = push_d & full_d & ~pop_d & ~fifo_clear;

    dfd_trace_hop_sink_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo_ntrace (
        .clk(clk), .reset(reset), .clear(fifo_clear), .push(push_n), .pop(pop_n),
        .wdata({core_idx, hop_tr_data}), .rdata(rdata_n), .full(full_n),
        .empty(empty_n), .free_next(free_n)
    );

    dfd_trace_hop_sink_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo_dst (
        .clk(clk), .reset(reset), .clear(fifo_clear), .push(push_d), .pop(pop_d),
        .wdata({core_idx, hop_tr_data}), .rdata(rdata_d), .full(full_d),
        .empty(empty_d), .free_next(free_d)
    );

    assign ntrace_out_vld                     = ~empty_n;
    assign {ntrace_out_core, ntrace_out_data} = rdata_n;
    assign dst_out_vld                        = ~empty_d;
    assign {dst_out_core, dst_out_data}       = rdata_d;

    // Backpressure once free space falls within the hop-chain skid allowance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hop_tr_ntrace_bp <= 1'b0;
            hop_tr_dst_bp    <= 1'b0;
        end else begin
            hop_tr_ntrace_bp <= (free_n <= FCW'(BP_SKID));
            hop_tr_dst_bp    <= (free_d <= FCW'(BP_SKID));
        end
    end

    // Flush requests forwarded upstream through one flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hop_tr_ntrace_flush <= 1'b0;
            hop_tr_dst_flush    <= 1'b0;
        end else begin
            hop_tr_ntrace_flush <= ntrace_flush_req;
            hop_tr_dst_flush    <= dst_flush_req;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_onehot <= 1'b0;
            ntrace_ovf <= 1'b0;
            dst_ovf    <= 1'b0;
        end else begin
            if (is_multi) err_onehot <= 1'b1;
            if (drop_n)   ntrace_ovf <= 1'b1;
            if (drop_d)   dst_ovf    <= 1'b1;
        end
    end

`ifdef DFD_TRACE_SINK_DROP_CNT_EN
    // Dropped-beat counters; multi-hot drops are charged to hop_tr_src's class
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ntrace_drop_cnt <= 16'd0;
            dst_drop_cnt    <= 16'd0;
        end else begin
            if (drop_n || (is_multi && hop_tr_src == CLS_NTRACE))
                ntrace_drop_cnt <= sat_inc16(ntrace_drop_cnt);
            if (drop_d || (is_multi && hop_tr_src == CLS_DST))
                dst_drop_cnt <= sat_inc16(dst_drop_cnt);
        end
    end
`endif

    // Enable FSM: any mask change goes through a zero-output quiesce window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= EN_IDLE;
            mask                <= {NUM_CORES_IN_PATH{1'b0}};
            qcnt                <= 2'd0;
            hop_tr_enabled_srcs <= {NUM_CORES_IN_PATH{1'b0}};
            fifo_clear          <= 1'b0;
        end else begin
            fifo_clear <= 1'b0;
            case (state)
                EN_IDLE: begin
                    if (cfg_enabled_srcs != {NUM_CORES_IN_PATH{1'b0}}) begin
                        state               <= EN_ACTIVE;
                        mask                <= cfg_enabled_srcs;
                        hop_tr_enabled_srcs <= cfg_enabled_srcs;
                    end
                end
                EN_ACTIVE: begin
                    if (cfg_enabled_srcs != mask) begin
                        state               <= EN_QUIESCE;
                        mask                <= cfg_enabled_srcs;
                        qcnt                <= 2'd0;
                        hop_tr_enabled_srcs <= {NUM_CORES_IN_PATH{1'b0}};
                    end
                end
                EN_QUIESCE: begin
                    if (cfg_enabled_srcs != mask) begin
                        mask <= cfg_enabled_srcs;
                        qcnt <= 2'd0;
                    end else if (qcnt == 2'(QUIESCE_LEN - 1)) begin
                        if (mask == {NUM_CORES_IN_PATH{1'b0}}) begin
                            state      <= EN_IDLE;
                            fifo_clear <= 1'b1;
                        end else begin
                            state               <= EN_ACTIVE;
                            hop_tr_enabled_srcs <= mask;
                        end
                    end else begin
                        qcnt <= qcnt + 2'd1;
                    end
                end
                default: begin
                    state               <= EN_IDLE;
                    hop_tr_enabled_srcs <= {NUM_CORES_IN_PATH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfd_trace_hop_sink.sv
// Self-checking bench for dfd_trace_hop_sink (default parameters): directed
// scenarios with literal expectations followed by a randomized run, all
// compared every cycle against a queue-based model of the sink.
`timescale 1ns/1ps
module tb_dfd_trace_hop_sink;

    localparam int N     = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int SKID  = 6;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  hop_tr_vld;
    logic          hop_tr_src;
    logic [DW-1:0] hop_tr_data;
    logic          hop_tr_ntrace_bp, hop_tr_dst_bp;
    logic          hop_tr_ntrace_flush, hop_tr_dst_flush;
    logic [N-1:0]  hop_tr_enabled_srcs;
    logic [N-1:0]  cfg_enabled_srcs;
    logic          ntrace_flush_req, dst_flush_req;
    logic          ntrace_out_vld, ntrace_out_rdy;
    logic [DW-1:0] ntrace_out_data;
    logic [CW-1:0] ntrace_out_core;
    logic          dst_out_vld, dst_out_rdy;
    logic [DW-1:0] dst_out_data;
    logic [CW-1:0] dst_out_core;
    logic          err_onehot, ntrace_ovf, dst_ovf;
`ifdef DFD_TRACE_SINK_DROP_CNT_EN
    logic [15:0]   ntrace_drop_cnt, dst_drop_cnt;
`endif

    always #5 clk = ~clk;

    dfd_trace_hop_sink dut (
        .clk(clk), .reset(reset),
        .hop_tr_vld(hop_tr_vld), .hop_tr_src(hop_tr_src), .hop_tr_data(hop_tr_data),
        .hop_tr_ntrace_bp(hop_tr_ntrace_bp), .hop_tr_dst_bp(hop_tr_dst_bp),
        .hop_tr_ntrace_flush(hop_tr_ntrace_flush), .hop_tr_dst_flush(hop_tr_dst_flush),
        .hop_tr_enabled_srcs(hop_tr_enabled_srcs), .cfg_enabled_srcs(cfg_enabled_srcs),
        .ntrace_flush_req(ntrace_flush_req), .dst_flush_req(dst_flush_req),
        .ntrace_out_vld(ntrace_out_vld), .ntrace_out_rdy(ntrace_out_rdy),
        .ntrace_out_data(ntrace_out_data), .ntrace_out_core(ntrace_out_core),
        .dst_out_vld(dst_out_vld), .dst_out_rdy(dst_out_rdy),
        .dst_out_data(dst_out_data), .dst_out_core(dst_out_core),
        .err_onehot(err_onehot), .ntrace_ovf(ntrace_ovf), .dst_ovf(dst_ovf)
`ifdef DFD_TRACE_SINK_DROP_CNT_EN
        , .ntrace_drop_cnt(ntrace_drop_cnt), .dst_drop_cnt(dst_drop_cnt)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] core;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state
    ent_t     q0[$];
    ent_t     q1[$];
    bit       m_bp0, m_bp1, m_fl0, m_fl1, m_err, m_ovf0, m_ovf1;
    int       m_drop0, m_drop1;
    bit       m_on, m_clr_pend;
    int       m_quiet;
    bit [N-1:0] m_mask, m_pend;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_bp0 = 0; m_bp1 = 0; m_fl0 = 0; m_fl1 = 0;
        m_err = 0; m_ovf0 = 0; m_ovf1 = 0; m_drop0 = 0; m_drop1 = 0;
        m_on = 0; m_clr_pend = 0; m_quiet = 0; m_mask = '0; m_pend = '0;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        int   pc;
        int   core;
        bit   clr;
        ent_t e;
        pc  = $countones(hop_tr_vld);
        clr = m_clr_pend;
        core = 0;
        for (int i = 0; i < N; i++) if (hop_tr_vld[i]) core = i;
        e.core = CW'(core);
        e.data = hop_tr_data;
        m_fl0 = ntrace_flush_req;
        m_fl1 = dst_flush_req;
        if (pc > 1) begin
            m_err = 1;
            if (hop_tr_src) m_drop1++; else m_drop0++;
        end
        if (clr) begin
            q0.delete(); q1.delete();
        end else begin
            if (q0.size() > 0 && ntrace_out_rdy) void'(q0.pop_front());
            if (q1.size() > 0 && dst_out_rdy)    void'(q1.pop_front());
            if (pc == 1) begin
                if (!hop_tr_src) begin
                    if (q0.size() < DEPTH) q0.push_back(e);
                    else begin m_ovf0 = 1; m_drop0++; end
                end else begin
                    if (q1.size() < DEPTH) q1.push_back(e);
                    else begin m_ovf1 = 1; m_drop1++; end
                end
            end
        end
        m_bp0 = (DEPTH - q0.size()) <= SKID;
        m_bp1 = (DEPTH - q1.size()) <= SKID;
        // Enable handshake: mask changes wait out two quiet cycles
        m_clr_pend = 0;
        if (m_quiet > 0) begin
            if (cfg_enabled_srcs != m_pend) begin
                m_pend  = cfg_enabled_srcs;
                m_quiet = 2;
            end else begin
                m_quiet--;
                if (m_quiet == 0) begin
                    if (m_pend == 0) begin m_on = 0; m_clr_pend = 1; end
                    else begin m_on = 1; m_mask = m_pend; end
                end
            end
        end else if (m_on) begin
            if (cfg_enabled_srcs != m_mask) begin
                m_on = 0; m_quiet = 2; m_pend = cfg_enabled_srcs;
            end
        end else if (cfg_enabled_srcs != 0) begin
            m_on = 1; m_mask = cfg_enabled_srcs;
        end
    endtask

    task automatic compare();
        bit [N-1:0] en_exp;
        en_exp = (m_on && m_quiet == 0) ? m_mask : '0;
        chk("n_vld", ntrace_out_vld, q0.size() != 0);
        if (q0.size() != 0) begin
            chk("n_data", ntrace_out_data, q0[0].data);
            chk("n_core", ntrace_out_core, q0[0].core);
        end
        chk("d_vld", dst_out_vld, q1.size() != 0);
        if (q1.size() != 0) begin
            chk("d_data", dst_out_data, q1[0].data);
            chk("d_core", dst_out_core, q1[0].core);
        end
        chk("n_bp", hop_tr_ntrace_bp, m_bp0);
        chk("d_bp", hop_tr_dst_bp, m_bp1);
        chk("n_flush", hop_tr_ntrace_flush, m_fl0);
        chk("d_flush", hop_tr_dst_flush, m_fl1);
        chk("enabled", hop_tr_enabled_srcs, en_exp);
        chk("err_onehot", err_onehot, m_err);
        chk("n_ovf", ntrace_ovf, m_ovf0);
        chk("d_ovf", dst_ovf, m_ovf1);
`ifdef DFD_TRACE_SINK_DROP_CNT_EN
        chk("n_drop", ntrace_drop_cnt, sat16(m_drop0));
        chk("d_drop", dst_drop_cnt, sat16(m_drop1));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit src, input int core, input logic [DW-1:0] data);
        hop_tr_vld  = 4'b0001 << core;
        hop_tr_src  = src;
        hop_tr_data = data;
    endtask

    task automatic idle_in();
        hop_tr_vld = 4'b0000;
    endtask

    initial begin
        logic [3:0] multi_tbl [8];
        int r;
        multi_tbl = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100, 4'b0111, 4'b1111};

        reset = 1'b1; hop_tr_vld = '0; hop_tr_src = 1'b0; hop_tr_data = '0;
        cfg_enabled_srcs = '0; ntrace_flush_req = 1'b0; dst_flush_req = 1'b0;
        ntrace_out_rdy = 1'b0; dst_out_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("rst_n_vld", ntrace_out_vld, 1'b0);
        chk("rst_bp", {hop_tr_ntrace_bp, hop_tr_dst_bp}, 2'b00);
        chk("rst_en", hop_tr_enabled_srcs, 4'b0000);
        reset = 1'b0;

        // Enable handshake
        cfg_enabled_srcs = 4'b0101;
        step(); chk("en_0101", hop_tr_enabled_srcs, 4'b0101);
        cfg_enabled_srcs = 4'b0111;
        step(); chk("en_q1", hop_tr_enabled_srcs, 4'b0000);
        step(); chk("en_q2", hop_tr_enabled_srcs, 4'b0000);
        step(); chk("en_0111", hop_tr_enabled_srcs, 4'b0111);

        // Flush forwarding
        ntrace_flush_req = 1'b1;
        step(); chk("flush_1", hop_tr_ntrace_flush, 1'b1);
        ntrace_flush_req = 1'b0;
        step(); chk("flush_0", hop_tr_ntrace_flush, 1'b0);

        // Backpressure threshold on ntrace
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, i % 4, DW'(i + 100));
            step();
            if (i == 8) chk("bp_after9", hop_tr_ntrace_bp, 1'b0);
        end
        chk("bp_after10", hop_tr_ntrace_bp, 1'b1);
        chk("dst_bp_quiet", hop_tr_dst_bp, 1'b0);
        idle_in();
        ntrace_out_rdy = 1'b1;
        repeat (10) step();
        ntrace_out_rdy = 1'b0;
        chk("n_drained", ntrace_out_vld, 1'b0);

        // Fill dst, then simultaneous push and pop at full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i % 4, DW'(i + 200));
            step();
        end
        chk("dst_full_cnt", q1.size(), 16);
        chk("dst_full_ovf", dst_ovf, 1'b0);
        dst_out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2, {16{8'hA5}});
            step();
        end
        idle_in();
        dst_out_rdy = 1'b0;
        step();
        chk("pp_ovf", dst_ovf, 1'b0);
        chk("pp_cnt", q1.size(), 16);
        chk("pp_core", dst_out_core, 2'd2);
        chk("pp_data", dst_out_data, {16{8'hA5}});

        // Overflow on the 17th beat
        drive(1'b1, 3, DW'(999));
        step();
        chk("ovf_dst", dst_ovf, 1'b1);
        chk("ovf_ntrace", ntrace_ovf, 1'b0);
`ifdef DFD_TRACE_SINK_DROP_CNT_EN
        chk("ovf_drop_cnt", dst_drop_cnt, 16'd1);
`endif

        // Multi-hot beat
        hop_tr_vld = 4'b0011; hop_tr_src = 1'b0; hop_tr_data = DW'(77);
        step();
        chk("multi_err", err_onehot, 1'b1);
        chk("multi_nopush", ntrace_out_vld, 1'b0);
        idle_in();

        // Asynchronous reset with entries queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1, DW'(i + 300));
            step();
        end
        idle_in();
        reset = 1'b1;
        #1;
        chk("arst_n_vld", ntrace_out_vld, 1'b0);
        chk("arst_d_vld", dst_out_vld, 1'b0);
        chk("arst_bp", {hop_tr_ntrace_bp, hop_tr_dst_bp}, 2'b00);
        chk("arst_en", hop_tr_enabled_srcs, 4'b0000);
        chk("arst_flags", {err_onehot, ntrace_ovf, dst_ovf}, 3'b000);
        model_reset();
        @(negedge clk);
        compare();
        reset = 1'b0;
        drive(1'b0, 3, DW'(55));
        step();
        chk("post_rst_beat", ntrace_out_vld, 1'b1);
        chk("post_rst_core", ntrace_out_core, 2'd3);
        idle_in();

        // Randomized traffic, readiness, flushes and mask changes
        for (int c = 0; c < 3000; c++) begin
            ntrace_out_rdy = ($urandom % 2) == 0;
            dst_out_rdy    = ($urandom % 2) == 0;
            ntrace_flush_req = ($urandom % 8) == 0;
            dst_flush_req    = ($urandom % 8) == 0;
            hop_tr_src  = $urandom % 2;
            hop_tr_data = {$urandom, $urandom, $urandom, $urandom};
            r = $urandom % 40;
            if (r < 12)      hop_tr_vld = 4'b0000;
            else if (r < 39) hop_tr_vld = 4'b0001 << ($urandom % 4);
            else             hop_tr_vld = multi_tbl[$urandom % 8];
            if (($urandom % 30) == 0) begin
                if (($urandom % 4) == 0) cfg_enabled_srcs = 4'b0000;
                else cfg_enabled_srcs = 4'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfd_trace_hop_sink.md
DFD_TRACE_HOP_SINK -- requirements
Module: dfd_trace_hop_sink

Interface
REQ-001 SHALL have parameter NUM_CORES_IN_PATH, default 4: width of the one-hot source-core valid vector.
REQ-002 SHALL have parameter DATA_WIDTH_IN_BYTES, default 16; DATA_WIDTH = DATA_WIDTH_IN_BYTES*8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, ≥4: entries per class FIFO.
REQ-004 SHALL have parameter BP_SKID, default 6, less than FIFO_DEPTH: free-entry threshold covering hop-chain round-trip latency.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- hop_tr_vld  in  NUM_CORES_IN_PATH  one-hot beat valid from last hop.
- hop_tr_src  in  1  0 = ntrace class, 1 = dst class.
- hop_tr_data  in  DATA_WIDTH  beat payload.
- hop_tr_ntrace_bp, hop_tr_dst_bp  out  1 each  per-class backpressure upstream.
- hop_tr_ntrace_flush, hop_tr_dst_flush  out  1 each  flush upstream.
- hop_tr_enabled_srcs  out  NUM_CORES_IN_PATH  enabled cores.
- cfg_enabled_srcs  in  NUM_CORES_IN_PATH  programmed enable mask.
- ntrace_flush_req, dst_flush_req  in  1 each  flush from funnel.
- ntrace_out_vld / dst_out_vld  out  1  class output valid.
- ntrace_out_rdy / dst_out_rdy  in  1  class output ready.
- ntrace_out_data / dst_out_data  out  DATA_WIDTH  payload.
- ntrace_out_core / dst_out_core  out  clog2(NUM_CORES_IN_PATH)  encoded source core.
- err_onehot, ntrace_ovf, dst_ovf  out  1 each  sticky error flags.

Function
REQ-006 SHALL treat a cycle with exactly one hop_tr_vld bit set as a beat; SHALL push {core index, data} into the FIFO selected by hop_tr_src.
REQ-007 SHALL drop a beat whose hop_tr_vld has more than one bit set and set err_onehot; zero bits set is idle.
REQ-008 SHALL drop a beat arriving at a full FIFO and set that class's ovf flag; FIFO contents are unaffected.
REQ-009 SHALL provide standard valid/ready output per class: pop on vld&rdy; data/core held stable while vld&~rdy; vld is combinational from FIFO not-empty (zero-cycle read).
REQ-010 SHALL allow simultaneous push and pop on a full FIFO: the pop frees the slot, push accepted, no overflow.
REQ-011 SHALL register per-class bp: bp = 1 in the cycle after free entries ≤ BP_SKID, else 0.
REQ-012 SHALL drive hop_tr_*_flush as the corresponding *_flush_req delayed by one flop.
REQ-013 SHALL run an enable FSM: IDLE (hop_tr_enabled_srcs=0) -> ACTIVE when cfg_enabled_srcs≠0; ACTIVE (output = latched mask) -> QUIESCE on any cfg_enabled_srcs change; QUIESCE (output=0) counts 2 cycles -> ACTIVE with the new mask, or -> IDLE if the new mask is 0.
REQ-014 SHALL ensure ACTIVE->IDLE passes through QUIESCE; a cfg change during QUIESCE restarts the 2-cycle count.
REQ-015 SHALL clear both FIFOs on the IDLE entry cycle; sticky flags clear only on reset.
REQ-016 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.

Reset
REQ-017 SHALL on reset: FSM=IDLE, FIFOs empty, all out_vld=0, bp=0, flush=0, hop_tr_enabled_srcs=0, sticky flags=0, counters=0.
REQ-018 SHALL apply reset asynchronously mid-operation, discarding in-flight data; the first beat is accepted 1 cycle after reset deasserts.

Configuration
REQ-019 SHALL support macro DFD_TRACE_SINK_DROP_CNT_EN: when defined, add outputs ntrace_drop_cnt and dst_drop_cnt, 16 bits each, saturating at 0xFFFF, incremented per dropped beat (overflow or one-hot error, attributed by hop_tr_src). When undefined, these ports and counters are absent.

Structure
REQ-020 SHALL place the class encoding (NTRACE=0, DST=1), the enable-FSM state enum and the quiesce length (2) in dfd_tn_pkg.
REQ-021 SHALL instantiate sub-module dfd_trace_hop_sink_fifo (parameterised width/depth, push/pop/full/empty/free count) twice.

Verification
REQ-022 SHALL check: cfg_enabled_srcs 0->4'b0101 -> hop_tr_enabled_srcs=4'b0101 within 1 cycle; then mask to 4'b0111 -> 0 for 2 cycles, then 4'b0111.
REQ-023 SHALL check: 10 ntrace beats with ntrace_out_rdy=0 (DEPTH 16, SKID 6) -> hop_tr_ntrace_bp rises the cycle after the 10th push; dst_bp stays 0.
REQ-024 SHALL check: 17 dst beats with rdy=0 -> 16 stored, dst_ovf=1, drop count=1 when the macro is defined.
REQ-025 SHALL check: hop_tr_vld=4'b0011 -> no push, err_onehot=1.
REQ-026 SHALL check: full FIFO with simultaneous push and pop -> count stays 16, no overflow, order preserved (core 2 data 0xA5.. out in order).
REQ-027 SHALL check: reset asserted with 5 entries queued -> out_vld=0 immediately, bp=0, enabled_srcs=0.
